// File: rtl/uart_pkg.sv
// Shared character codes, state encoding and rate decode for the UART mode parser.
package uart_pkg;

    localparam logic [7:0] CH_NUL  = 8'h00;
    localparam logic [7:0] CH_M_U  = 8'h4D;
    localparam logic [7:0] CH_M_L  = 8'h6D;
    localparam logic [7:0] CH_F_U  = 8'h46;
    localparam logic [7:0] CH_F_L  = 8'h66;
    localparam logic [7:0] CH_1    = 8'h31;
    localparam logic [7:0] CH_5    = 8'h35;
    localparam logic [7:0] CH_A_U  = 8'h41;
    localparam logic [7:0] CH_A_L  = 8'h61;
    localparam logic [7:0] CH_B_U  = 8'h42;
    localparam logic [7:0] CH_B_L  = 8'h62;

    typedef enum logic {
        ST_DATA = 1'b0,
        ST_CMD  = 1'b1
    } state_t;

    typedef struct packed {
        logic       hit;
        logic [1:0] code;
    } rate_hit_t;

    // Map a rate-select character to its 2-bit code; hit=0 for anything else.
    function automatic rate_hit_t char_to_rate(input logic [7:0] ch);
        rate_hit_t r;
        r.hit  = 1'b1;
        r.code = 2'd0;
        case (ch)
            CH_1:           r.code = 2'd0;
            CH_5:           r.code = 2'd1;
            CH_A_U, CH_A_L: r.code = 2'd2;
            CH_B_U, CH_B_L: r.code = 2'd3;
            default:        r.hit  = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/uart_mode_parser_sync_fifo.sv
// First-word fall-through synchronous FIFO; the head entry is always on rd_data.
module sync_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic                          pop,
    input  logic [DATA_W-1:0]             wr_data,
    output logic [DATA_W-1:0]             rd_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              do_push;
    logic              do_pop;

    // A full FIFO still accepts a push when the same cycle pops.
    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
    end

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    // Pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(FIFO_DEPTH));
    assign level   = count;

endmodule

// File: rtl/uart_mode_parser.sv
// Splits the UART receive stream into FIFO-buffered data and in-band rate commands.
//   state   | meaning
//   ST_DATA | bytes go to the data FIFO; 'M'/'m' enters command mode
//   ST_CMD  | bytes select the rate; 'F'/'f' or an idle timeout returns to data
module uart_mode_parser
    import uart_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int FIFO_DEPTH  = 8,
    parameter int RATE_W      = 2,
    parameter int TIMEOUT_CYC = 1000000,
    parameter int RATE_RST    = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_valid,
    input  logic [DATA_W-1:0]             i_data,
    output logic [DATA_W-1:0]             o_data,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [RATE_W-1:0]             o_rate,
    output logic                          o_cmd_mode,
    output logic                          o_start,
    output logic                          o_rate_upd,
    output logic                          o_err,
    output logic                          o_ovf,
    output logic [$clog2(FIFO_DEPTH):0]   o_level
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic [7:0]        ch;
    logic              byte_ok;
    logic              is_m;
    logic              is_f;
    rate_hit_t         rh;
    logic              rate_ok;
    logic [RATE_W-1:0] new_rate;
    logic              push_req;
    logic              rate_load;
    logic              err_set;
    logic              err_clr;
    logic              pop;
    logic              fifo_push;
    logic              fifo_full;
    logic              fifo_empty;

    assign ch       = i_data[7:0];
    assign byte_ok  = i_valid && (ch != CH_NUL);
    assign is_m     = (ch == CH_M_U) || (ch == CH_M_L);
    assign is_f     = (ch == CH_F_U) || (ch == CH_F_L);
    assign rh       = char_to_rate(ch);
    assign rate_ok  = rh.hit && (int'(rh.code) < (1 << RATE_W));
    assign new_rate = RATE_W'(rh.code);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_DATA;
        else        state <= state_next;
    end

    // Next-state and per-byte actions; a byte arriving on the last idle cycle wins over the timeout.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        push_req   = 1'b0;
        rate_load  = 1'b0;
        err_set    = 1'b0;
        err_clr    = 1'b0;
        case (state)
            ST_DATA: begin
                cnt_next = '0;
                if (byte_ok) begin
                    if (is_m) begin
                        state_next = ST_CMD;
                        err_clr    = 1'b1;
                    end else if (!is_f) begin
                        push_req = 1'b1;
                    end
                end
            end
            ST_CMD: begin
                if (byte_ok) begin
                    cnt_next = '0;
                    if (is_f)         state_next = ST_DATA;
                    else if (is_m)    state_next = ST_CMD;
                    else if (rate_ok) rate_load  = 1'b1;
                    else              err_set    = 1'b1;
                end else if ((TIMEOUT_CYC != 0) && (cnt == CNT_LAST)) begin
                    state_next = ST_DATA;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: state_next = ST_DATA;
        endcase
    end

    assign pop       = o_valid && i_ready;
    assign fifo_push = push_req && (!fifo_full || pop);

    // Timeout counter, rate register and status flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt        <= '0;
            o_rate     <= RATE_W'(RATE_RST);
            o_rate_upd <= 1'b0;
            o_err      <= 1'b0;
            o_ovf      <= 1'b0;
        end else begin
            cnt        <= cnt_next;
            o_rate_upd <= rate_load && (new_rate != o_rate);
            if (rate_load) o_rate <= new_rate;
            if (err_clr)      o_err <= 1'b0;
            else if (err_set) o_err <= 1'b1;
            o_ovf <= push_req && fifo_full && !pop;
        end
    end

    assign o_cmd_mode = (state == ST_CMD);
    assign o_start    = !o_cmd_mode;

    sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (fifo_push),
        .pop     (pop),
        .wr_data (i_data),
        .rd_data (o_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (o_level)
    );

    assign o_valid = !fifo_empty;

endmodule
